// File: rtl/fib_pkg.sv
// Shared types and helpers for the Fibonacci request scheduler.
package fib_pkg;

    localparam int unsigned FIB_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } fib_sched_state_t;

    typedef struct packed {
        logic [FIB_WIDTH-1:0] n;
    } fib_req_t;

    typedef struct packed {
        logic [FIB_WIDTH-1:0] n;
        logic [FIB_WIDTH-1:0] fib;
        logic                 ovf;
    } fib_rsp_t;

    // Largest n whose F(n) still fits in 'width' bits.
    function automatic int unsigned fib_nmax(input int unsigned width);
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] t;
        logic [127:0] lim;
        int unsigned  n;
        lim = 128'd1 << width;
        a   = '0;
        b   = 128'd1;
        n   = 0;
        while (b < lim) begin
            t = a + b;
            a = b;
            b = t;
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/fib_req_fifo.sv
// Request FIFO (DEPTH x WIDTH) with registered full/empty flags and
// simultaneous push/pop.
module fib_req_fifo
    import fib_pkg::*;
#(
    parameter int unsigned WIDTH = FIB_WIDTH,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_d;

    assign dout = mem[rd_ptr];

    always_comb begin
        count_d = CNT_W'(count + CNT_W'(push) - CNT_W'(pop));
    end

    // Held full during reset so no push can be accepted then.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b1;
        end else begin
            if (push) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
            if (pop)  rd_ptr <= PTR_W'(rd_ptr + 1'b1);
            count <= count_d;
            empty <= (count_d == '0);
            full  <= (count_d == CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fib_req_sched.sv
// Fibonacci request scheduler: queues index requests, runs them one at a time
// through fibonacci_gen, returns results. FIB_SCHED_OVF_CHECK_EN enables saturation.
module fib_req_sched
    import fib_pkg::*;
#(
    parameter int unsigned WIDTH       = FIB_WIDTH,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned GEN_LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_n,
    output logic             gen_start,
    output logic [WIDTH-1:0] gen_n,
    input  logic [WIDTH-1:0] gen_fib,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_n,
    output logic [WIDTH-1:0] rsp_fib,
    output logic             rsp_ovf
);

    localparam int unsigned CNT_W = (GEN_LATENCY > 1) ? $clog2(GEN_LATENCY) : 1;

    fib_sched_state_t state;
    fib_sched_state_t state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic             fifo_full;
    logic [WIDTH-1:0] head;
    logic             head_ovf;
    logic             gen_start_d;
    logic [WIDTH-1:0] gen_n_d;
    logic             rsp_valid_d;
    logic [WIDTH-1:0] rsp_n_d;
    logic [WIDTH-1:0] rsp_fib_d;
    logic             rsp_ovf_d;

    assign req_ready = !fifo_full;
    assign push      = req_valid && req_ready;

    fib_req_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (req_n),
        .pop   (pop),
        .dout  (head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

`ifdef FIB_SCHED_OVF_CHECK_EN
    localparam int unsigned NMAX = fib_nmax(WIDTH);
    assign head_ovf = (32'(head) > NMAX);
`else
    assign head_ovf = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = head_ovf ? HOLD : ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT:  if (cnt == '0) state_d = HOLD;
            HOLD:  if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and the latency counter.
    always_comb begin
        gen_start_d = 1'b0;
        gen_n_d     = gen_n;
        rsp_n_d     = rsp_n;
        rsp_fib_d   = rsp_fib;
        rsp_ovf_d   = rsp_ovf;
        cnt_d       = cnt;
        rsp_valid_d = (state_d == HOLD);
        case (state)
            IDLE: begin
                if (pop) begin
                    gen_n_d     = head;
                    rsp_n_d     = head;
                    rsp_ovf_d   = head_ovf;
                    gen_start_d = !head_ovf;
                    if (head_ovf) rsp_fib_d = '1;
                end
            end
            ISSUE: cnt_d = CNT_W'(GEN_LATENCY - 1);
            WAIT: begin
                if (cnt == '0) rsp_fib_d = gen_fib;
                else           cnt_d     = CNT_W'(cnt - 1'b1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gen_start <= 1'b0;
            gen_n     <= '0;
            rsp_valid <= 1'b0;
            rsp_n     <= '0;
            rsp_fib   <= '0;
            rsp_ovf   <= 1'b0;
            cnt       <= '0;
        end else begin
            gen_start <= gen_start_d;
            gen_n     <= gen_n_d;
            rsp_valid <= rsp_valid_d;
            rsp_n     <= rsp_n_d;
            rsp_fib   <= rsp_fib_d;
            rsp_ovf   <= rsp_ovf_d;
            cnt       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fib_req_sched.sv
// Self-checking bench for fib_req_sched with a behavioural fixed-latency generator.
module tb_fib_req_sched;
    import fib_pkg::*;

    localparam int unsigned W = 8;
    localparam int unsigned D = 4;
    localparam int unsigned L = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_n;
    logic         gen_start;
    logic [W-1:0] gen_n;
    logic [W-1:0] gen_fib;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_n;
    logic [W-1:0] rsp_fib;
    logic         rsp_ovf;

    int       checks = 0;
    int       fails  = 0;
    int       cyc    = 0;
    int       gen_starts = 0;
    int       rsp_cnt = 0;
    fib_rsp_t sb[$];
    int       rsp_cyc[$];
    fib_rsp_t mon_got;
    fib_rsp_t mon_exp;

    logic         gen_busy = 1'b0;
    int           gen_cnt  = 0;
    logic [W-1:0] gen_res  = '0;
    logic [W-1:0] gen_res_n = '0;

    fib_req_sched #(
        .WIDTH       (W),
        .DEPTH       (D),
        .GEN_LATENCY (L)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_n     (req_n),
        .gen_start (gen_start),
        .gen_n     (gen_n),
        .gen_fib   (gen_fib),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_n     (rsp_n),
        .rsp_fib   (rsp_fib),
        .rsp_ovf   (rsp_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic fib_rsp_t ref_rsp(input logic [W-1:0] n);
        fib_rsp_t    r;
        int unsigned a;
        int unsigned b;
        int unsigned t;
        a = 0;
        b = 1;
        for (int i = 0; i < int'(n); i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        r.n   = n;
        r.fib = a[7:0];
        r.ovf = 1'b0;
`ifdef FIB_SCHED_OVF_CHECK_EN
        if (n > 8'd13) begin
            r.fib = 8'hFF;
            r.ovf = 1'b1;
        end
`endif
        return r;
    endfunction

    // Generator: result valid only in cycle S+L after a start in cycle S.
    always @(posedge clk) begin
        if (rst) begin
            gen_busy <= 1'b0;
        end else if (gen_start) begin
            gen_busy  <= 1'b1;
            gen_cnt   <= L - 1;
            gen_res   <= ref_rsp(gen_n).fib;
            gen_res_n <= gen_n;
        end else if (gen_busy) begin
            if (gen_cnt == 0) gen_busy <= 1'b0;
            else              gen_cnt  <= gen_cnt - 1;
        end
    end
    assign gen_fib = (gen_busy && gen_cnt == 0) ? gen_res : 8'hA5;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard push on request handshake, pop and compare on response handshake.
    always @(negedge clk) begin
        if (!rst && req_valid && req_ready) sb.push_back(ref_rsp(req_n));
        if (!rst && rsp_valid && rsp_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL stale_rsp: observed response n=%0d while none expected", rsp_n);
            end
            if (sb.size() != 0) begin
                mon_exp     = sb.pop_front();
                mon_got.n   = rsp_n;
                mon_got.fib = rsp_fib;
                mon_got.ovf = rsp_ovf;
                checks++;
                assert (mon_got === mon_exp) else begin
                    fails++;
                    $error("FAIL rsp_order: observed n=%0d fib=%0d ovf=%0b expected n=%0d fib=%0d ovf=%0b",
                           mon_got.n, mon_got.fib, mon_got.ovf, mon_exp.n, mon_exp.fib, mon_exp.ovf);
                end
            end
            rsp_cyc.push_back(cyc);
            rsp_cnt++;
        end
        if (gen_start) gen_starts++;
        if (!rst && gen_busy) check("gen_n_stable", 32'(gen_n), 32'(gen_res_n));
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push1(input logic [W-1:0] n, input string tag);
        req_valid = 1'b1;
        req_n     = n;
        check(tag, 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp_valid(input string tag);
        int k;
        k = 0;
        while (!rsp_valid && k < 50) begin
            step();
            k++;
        end
        check(tag, 32'(rsp_valid), 32'd1);
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((sb.size() != 0 || rsp_valid) && k < 300) begin
            step();
            k++;
        end
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int base;
        int gs;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_n     = '0;
        rsp_ready = 1'b0;
        step(2);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_outputs", 32'({gen_start, gen_n, rsp_valid, rsp_n, rsp_fib, rsp_ovf}), 32'd0);
        rst = 1'b0;
        step();
        check("ready_after_rst", 32'(req_ready), 32'd1);

        // Single request latency
        rsp_ready = 1'b1;
        push1(8'd10, "t1_accept");
        check("t1_no_start_early", 32'(gen_start), 32'd0);
        step();
        check("t1_start", 32'(gen_start), 32'd1);
        check("t1_gen_n", 32'(gen_n), 32'd10);
        step();
        check("t1_start_one_cycle", 32'(gen_start), 32'd0);
        check("t1_no_rsp_t3", 32'(rsp_valid), 32'd0);
        step();
        check("t1_no_rsp_t4", 32'(rsp_valid), 32'd0);
        step();
        check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t1_rsp_fib", 32'(rsp_fib), 32'd55);
        check("t1_rsp_n", 32'(rsp_n), 32'd10);
        check("t1_rsp_ovf", 32'(rsp_ovf), 32'd0);
        step();
        check("t1_rsp_cleared", 32'(rsp_valid), 32'd0);

        // Back-to-back F(0), F(1)
        base = rsp_cnt;
        push1(8'd0, "t2_accept0");
        push1(8'd1, "t2_accept1");
        drain("t2_drain");
        check("t2_count", 32'(rsp_cnt - base), 32'd2);
        check("t2_spacing", 32'(rsp_cyc[rsp_cyc.size()-1] - rsp_cyc[rsp_cyc.size()-2]), 32'd5);

        // Backpressure: 1 in flight + 4 queued, 6th refused
        rsp_ready = 1'b0;
        base = rsp_cnt;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1;
            req_n     = W'(3 + i);
            check($sformatf("t3_ready_%0d", i), 32'(req_ready), (i < 5) ? 32'd1 : 32'd0);
            step();
        end
        req_valid = 1'b0;
        wait_rsp_valid("t3_hold_reached");
        check("t3_hold_n", 32'(rsp_n), 32'd3);
        check("t3_hold_fib", 32'(rsp_fib), 32'd2);
        check("t3_full", 32'(req_ready), 32'd0);
        step(3);
        check("t3_hold_stable", 32'({rsp_valid, rsp_n, rsp_fib, rsp_ovf}), 32'({1'b1, 8'd3, 8'd2, 1'b0}));
        rsp_ready = 1'b1;
        drain("t3_drain");
        check("t3_count", 32'(rsp_cnt - base), 32'd5);

        // Push and pop in the same cycle with 3 queued
        rsp_ready = 1'b0;
        base = rsp_cnt;
        push1(8'd9,  "t6_push_a");
        push1(8'd10, "t6_push_b");
        push1(8'd11, "t6_push_c");
        push1(8'd12, "t6_push_d");
        wait_rsp_valid("t6_hold");
        check("t6_ready_at_3", 32'(req_ready), 32'd1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        push1(8'd5, "t6_push_pop");
        check("t6_occ_3", 32'(req_ready), 32'd1);
        push1(8'd6, "t6_push_fill");
        check("t6_full", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        drain("t6_drain");
        check("t6_count", 32'(rsp_cnt - base), 32'd6);

        // Index above the 8-bit limit, then the limit itself
        gs = gen_starts;
        push1(8'd14, "t5_accept14");
`ifdef FIB_SCHED_OVF_CHECK_EN
        step();
        check("t5_ovf_valid", 32'(rsp_valid), 32'd1);
        check("t5_ovf_fib", 32'(rsp_fib), 32'hFF);
        check("t5_ovf_flag", 32'(rsp_ovf), 32'd1);
        check("t5_ovf_n", 32'(rsp_n), 32'd14);
        step();
        check("t5_no_start", 32'(gen_starts - gs), 32'd0);
`else
        drain("t5_drain14");
        check("t5_start_issued", 32'(gen_starts - gs), 32'd1);
`endif
        push1(8'd13, "t5_accept13");
        drain("t5_drain13");

        // Reset during WAIT drops in-flight and queued requests
        rsp_ready = 1'b1;
        push1(8'd5, "t4_push_a");
        push1(8'd6, "t4_push_b");
        check("t4_issue", 32'(gen_start), 32'd1);
        step();
        rst = 1'b1;
        sb.delete();
        step();
        check("t4_rst_outputs", 32'({gen_start, gen_n, rsp_valid, rsp_n, rsp_fib, rsp_ovf}), 32'd0);
        check("t4_rst_ready", 32'(req_ready), 32'd0);
        step();
        check("t4_rst_ready_hold", 32'(req_ready), 32'd0);
        rst = 1'b0;
        step();
        check("t4_ready_after", 32'(req_ready), 32'd1);
        gs   = gen_starts;
        base = rsp_cnt;
        step(20);
        check("t4_no_stale_start", 32'(gen_starts - gs), 32'd0);
        check("t4_no_stale_rsp", 32'(rsp_cnt - base), 32'd0);
        check("t4_rsp_low", 32'(rsp_valid), 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
